// File: rtl/riscfw_pkg.sv
// Shared definitions for the fetch front end: widths, fetch FSM encoding and
// the word that stops the fetch stream.
package riscfw_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    // Fetch FSM encoding
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // All-zero word: treated as the end of the program
    localparam logic [INSTR_W-1:0] ILLEGAL_ZERO_INSTR = 32'h0;

    // Instruction addresses are word aligned; the low two bits are dropped
    localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    // Fetch advance step in bytes
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    // True when the fetched word is the all-zero stop word
    function automatic logic is_zero_word(input logic [INSTR_W-1:0] word);
        return (word == ILLEGAL_ZERO_INSTR);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// IF/ID handshake bundle between fetch (master) and decode (slave).
interface fetch_stage_if;
    import riscfw_pkg::*;

    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic               out_illegal;

    modport master (
        output out_valid,
        output out_pc,
        output out_instr,
        output out_illegal,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_pc,
        input  out_instr,
        input  out_illegal,
        output out_ready
    );

endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: captures {pc, instr, illegal} on load, keeps its
// contents while neither load, flush nor drain is requested.
module ifid_reg
    import riscfw_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic               i_flush,
    input  logic               i_drain,
    input  logic [XLEN-1:0]    i_pc,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic               i_illegal,
    output logic               o_valid,
    output logic [XLEN-1:0]    o_pc,
    output logic [INSTR_W-1:0] o_instr,
    output logic               o_illegal
);

    logic               r_valid;
    logic [XLEN-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic               r_illegal;

    // Valid/illegal flags: flush beats load, load beats drain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (i_flush) begin
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (i_load) begin
            r_valid   <= 1'b1;
            r_illegal <= i_illegal;
        end else if (i_drain) begin
            r_valid   <= 1'b0;
        end
    end

    // Payload only changes when a new instruction is captured
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= '0;
            r_instr <= '0;
        end else if (i_load && !i_flush) begin
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end
    end

    assign o_valid   = r_valid;
    assign o_pc      = r_pc;
    assign o_instr   = r_instr;
    assign o_illegal = r_illegal;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the combinational icache, fills the
// IF/ID register and stops on an all-zero word until execute redirects it.
module fetch_stage
    import riscfw_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC     = 32'h0,
    parameter bit              HALT_ON_ZERO = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    output logic [XLEN-1:0]    icache_addr,
    input  logic [INSTR_W-1:0] icache_instr,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    fetch_stage_if.master      dec,
    output logic               halted,
    output logic [XLEN-1:0]    fetch_count
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_fetch_count;
    logic               r_halted;

    logic               w_out_valid;
    logic [XLEN-1:0]    w_out_pc;
    logic [INSTR_W-1:0] w_out_instr;
    logic               w_out_illegal;

    logic               w_hold;
    logic               w_advance;
    logic               w_illegal;
    logic               w_handshake;
    logic               w_drain;
    logic [XLEN-1:0]    w_redirect_target;

    assign w_hold            = w_out_valid && !dec.out_ready;
    assign w_advance         = (r_state == RUN) && !w_hold && !redirect_valid;
    assign w_illegal         = HALT_ON_ZERO && is_zero_word(icache_instr);
    assign w_handshake       = w_out_valid && dec.out_ready && !redirect_valid;
    // Decode took the word but nothing refills it (IDLE/HALTED, no redirect)
    assign w_drain           = dec.out_ready && !w_advance && !redirect_valid;
    assign w_redirect_target = redirect_pc & PC_ALIGN_MASK;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: redirect wins in every state
    always_comb begin
        w_state_next = r_state;
        if (redirect_valid) begin
            w_state_next = RUN;
        end else begin
            case (r_state)
                IDLE:    w_state_next = RUN;
                RUN:     if (w_advance && w_illegal) w_state_next = HALTED;
                HALTED:  w_state_next = HALTED;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Halted flag registered alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_halted <= 1'b0;
        end else begin
            r_halted <= (w_state_next == HALTED);
        end
    end

    // Program counter: redirect, else step past every legal fetched word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= w_redirect_target;
        end else if (w_advance && !w_illegal) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

    // Completed decode handshakes; discarded words are not counted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_count <= '0;
        end else if (w_handshake) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    ifid_reg u_ifid_reg (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_advance),
        .i_flush   (redirect_valid),
        .i_drain   (w_drain),
        .i_pc      (r_pc),
        .i_instr   (icache_instr),
        .i_illegal (w_illegal),
        .o_valid   (w_out_valid),
        .o_pc      (w_out_pc),
        .o_instr   (w_out_instr),
        .o_illegal (w_out_illegal)
    );

    assign icache_addr     = r_pc;
    assign halted          = r_halted;
    assign fetch_count     = r_fetch_count;
    assign dec.out_valid   = w_out_valid;
    assign dec.out_pc      = w_out_pc;
    assign dec.out_instr   = w_out_instr;
    assign dec.out_illegal = w_out_illegal;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a four-word program in a combinational
// instruction memory; every other address reads as zero.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] icache_addr;
    logic [31:0] icache_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic [31:0] fetch_count;

    int checks;
    int errors;

    fetch_stage_if u_if ();

    fetch_stage #(
        .RESET_PC     (32'h0),
        .HALT_ON_ZERO (1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .icache_addr    (icache_addr),
        .icache_instr   (icache_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec            (u_if),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory
    always_comb begin
        icache_instr = 32'h0;
        case (icache_addr)
            32'h0:   icache_instr = 32'h02a00313;
            32'h4:   icache_instr = 32'h006383b3;
            32'h8:   icache_instr = 32'h3e800e13;
            32'hC:   icache_instr = 32'hffc3cae3;
            default: icache_instr = 32'h0;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        u_if.out_ready = 1'b0;
        #12;
        checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", u_if.out_valid); end
        checks++; if (u_if.out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", u_if.out_pc); end
        checks++; if (u_if.out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", u_if.out_instr); end
        checks++; if (u_if.out_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b expected 0", u_if.out_illegal); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fetch_count); end
        checks++; if (icache_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", icache_addr); end
        @(negedge clk);
        reset = 1'b0;
        step();
        checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected 0", u_if.out_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc [4];
        logic [31:0] exp_in [4];
        exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_in = '{32'h02a00313, 32'h006383b3, 32'h3e800e13, 32'hffc3cae3};
        do_reset();
        u_if.out_ready = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (u_if.out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, u_if.out_valid); end
            checks++; if (u_if.out_pc !== exp_pc[i]) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, u_if.out_pc, exp_pc[i]); end
            checks++; if (u_if.out_instr !== exp_in[i]) begin errors++; $display("FAIL stream_instr[%0d]: got %h expected %h", i, u_if.out_instr, exp_in[i]); end
            checks++; if (fetch_count !== 32'(i)) begin errors++; $display("FAIL stream_count[%0d]: got %0d expected %0d", i, fetch_count, i); end
        end
        step();
        checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL stream_count_final: got %0d expected 4", fetch_count); end
    endtask

    task automatic test_hold();
        do_reset();
        u_if.out_ready = 1'b0;
        step();
        step();
        checks++; if (u_if.out_valid !== 1'b1) begin errors++; $display("FAIL hold_first_valid: got %b expected 1", u_if.out_valid); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (u_if.out_pc !== 32'h0) begin errors++; $display("FAIL hold_pc[%0d]: got %h expected 0", i, u_if.out_pc); end
            checks++; if (u_if.out_instr !== 32'h02a00313) begin errors++; $display("FAIL hold_instr[%0d]: got %h expected 02a00313", i, u_if.out_instr); end
            checks++; if (icache_addr !== 32'h4) begin errors++; $display("FAIL hold_addr[%0d]: got %h expected 4", i, icache_addr); end
            checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL hold_count[%0d]: got %0d expected 0", i, fetch_count); end
        end
        u_if.out_ready = 1'b1;
        step();
        checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL hold_release_count: got %0d expected 1", fetch_count); end
        checks++; if (u_if.out_pc !== 32'h4) begin errors++; $display("FAIL hold_release_pc: got %h expected 4", u_if.out_pc); end
    endtask

    task automatic test_redirect();
        do_reset();
        u_if.out_ready = 1'b1;
        step();
        step();
        step();
        step();
        step();
        checks++; if (u_if.out_pc !== 32'hC) begin errors++; $display("FAIL redir_pre_pc: got %h expected c", u_if.out_pc); end
        u_if.out_ready = 1'b0;
        step();
        checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL redir_hold_count: got %0d expected 3", fetch_count); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        u_if.out_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush_valid: got %b expected 0", u_if.out_valid); end
        checks++; if (icache_addr !== 32'h0) begin errors++; $display("FAIL redir_addr: got %h expected 0", icache_addr); end
        checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL redir_discard_count: got %0d expected 3", fetch_count); end
        step();
        checks++; if (u_if.out_valid !== 1'b1 || u_if.out_pc !== 32'h0) begin errors++; $display("FAIL redir_refetch: got valid=%b pc=%h expected valid=1 pc=0", u_if.out_valid, u_if.out_pc); end
        checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL redir_after_count: got %0d expected 3", fetch_count); end
        // Unaligned target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h6;
        step();
        redirect_valid = 1'b0;
        checks++; if (icache_addr !== 32'h4) begin errors++; $display("FAIL unaligned_addr: got %h expected 4", icache_addr); end
        checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL unaligned_flush: got %b expected 0", u_if.out_valid); end
        step();
        checks++; if (u_if.out_pc !== 32'h4 || u_if.out_instr !== 32'h006383b3) begin errors++; $display("FAIL unaligned_fetch: got pc=%h instr=%h expected pc=4 instr=006383b3", u_if.out_pc, u_if.out_instr); end
    endtask

    task automatic test_halt();
        do_reset();
        u_if.out_ready = 1'b1;
        step();
        for (int i = 0; i < 4; i++) step();
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early: got %b expected 0", halted); end
        step();
        checks++; if (u_if.out_pc !== 32'h10 || u_if.out_instr !== 32'h0) begin errors++; $display("FAIL halt_word: got pc=%h instr=%h expected pc=10 instr=0", u_if.out_pc, u_if.out_instr); end
        checks++; if (u_if.out_illegal !== 1'b1) begin errors++; $display("FAIL halt_illegal: got %b expected 1", u_if.out_illegal); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b expected 1", halted); end
        checks++; if (icache_addr !== 32'h10) begin errors++; $display("FAIL halt_addr: got %h expected 10", icache_addr); end
        step();
        checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL halt_drain: got %b expected 0", u_if.out_valid); end
        checks++; if (fetch_count !== 32'd5) begin errors++; $display("FAIL halt_count: got %0d expected 5", fetch_count); end
        step();
        step();
        checks++; if (u_if.out_valid !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL halt_stay: got valid=%b halted=%b expected valid=0 halted=1", u_if.out_valid, halted); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step();
        redirect_valid = 1'b0;
        checks++; if (halted !== 1'b0 || icache_addr !== 32'h0) begin errors++; $display("FAIL halt_exit: got halted=%b addr=%h expected halted=0 addr=0", halted, icache_addr); end
        step();
        checks++; if (u_if.out_valid !== 1'b1 || u_if.out_pc !== 32'h0 || u_if.out_illegal !== 1'b0) begin errors++; $display("FAIL halt_resume: got valid=%b pc=%h illegal=%b expected 1/0/0", u_if.out_valid, u_if.out_pc, u_if.out_illegal); end
    endtask

    task automatic test_async_reset();
        do_reset();
        u_if.out_ready = 1'b1;
        step();
        step();
        step();
        checks++; if (icache_addr !== 32'h8 || fetch_count !== 32'd1) begin errors++; $display("FAIL areset_pre: got addr=%h count=%0d expected addr=8 count=1", icache_addr, fetch_count); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b expected 0", u_if.out_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL areset_halted: got %b expected 0", halted); end
        checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL areset_count: got %0d expected 0", fetch_count); end
        checks++; if (icache_addr !== 32'h0) begin errors++; $display("FAIL areset_addr: got %h expected 0", icache_addr); end
        @(negedge clk);
        reset = 1'b0;
        step();
        checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL areset_edge1: got %b expected 0", u_if.out_valid); end
        step();
        checks++; if (u_if.out_valid !== 1'b1 || u_if.out_pc !== 32'h0) begin errors++; $display("FAIL areset_edge2: got valid=%b pc=%h expected valid=1 pc=0", u_if.out_valid, u_if.out_pc); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_stream();
        test_hold();
        test_redirect();
        test_halt();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
